amplitude_ramp_ctrl: RTL and testbench

- Parametrised keyboard-driven output-level controller for the synthesizer audio path.
- Converts USB HID keycodes into a volume level 0..MAX_LEVEL, with digit, step-up/down and mute keys.
- Drives a slew-limited amplitude word that ramps toward the target, so level changes are click-free.
- Sits between the keycode source and the mixer's amplitude multiplier.

---
 rtl/amplitude_ramp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_amplitude_ramp_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/amplitude_ramp_ctrl.sv
// Keycode-driven volume level controller with a slew-limited amplitude output.
// Define AMP_MUTE_EN to enable the mute-toggle key (8'h10).
module amplitude_ramp_ctrl #(
  parameter int unsigned      AMP_W     = 16,
  parameter int unsigned      MAX_LEVEL = 8,
  parameter logic [AMP_W-1:0] RAMP_STEP = AMP_W'(16'h0800),
  parameter int unsigned      RAMP_DIV  = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       keycode,
  output logic [AMP_W-1:0] amplitude,
  output logic [3:0]       level,
  output logic             muted,
  output logic             ramping
);

  localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned NUM_W = AMP_W + 5;
  localparam int unsigned LVL_N = 16;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [3:0]       LVL_MAX  = 4'(MAX_LEVEL);

  localparam logic [7:0] KEY_NONE   = 8'h00;
  localparam logic [7:0] KEY_ZERO   = 8'h35;
  localparam logic [7:0] KEY_DIG_LO = 8'h1E;
  localparam logic [7:0] KEY_DIG_HI = 8'h25;
  localparam logic [7:0] KEY_DIG_BS = 8'h1D;
  localparam logic [7:0] KEY_UP     = 8'h2E;
  localparam logic [7:0] KEY_DN     = 8'h2D;
`ifdef AMP_MUTE_EN
  localparam logic [7:0] KEY_MUTE   = 8'h10;
`endif

  // Level-to-amplitude target; the top level saturates to full scale.
  function automatic logic [AMP_W-1:0] tgt_f(input int unsigned lvl);
    logic [NUM_W-1:0] num;
    if (lvl >= MAX_LEVEL) begin
      return '1;
    end
    num = NUM_W'(lvl) << AMP_W;
    return AMP_W'(num / NUM_W'(MAX_LEVEL));
  endfunction

  logic [AMP_W-1:0] w_tgt_tbl [LVL_N];

  for (genvar g = 0; g < LVL_N; g++) begin : g_tgt
    assign w_tgt_tbl[g] = tgt_f(g);
  end

  logic [AMP_W-1:0] r_amp;
  logic [3:0]       r_level;
  logic [7:0]       r_prev_key;
  logic [CNT_W-1:0] r_tick;

  logic             w_accept;
  logic             w_lvl_cmd;
  logic             w_cmd;
  logic             w_step;
  logic [3:0]       w_digit;
  logic [3:0]       w_level_nxt;
  logic             w_muted;
  logic [AMP_W-1:0] w_eff_tgt;
  logic [AMP_W:0]   w_sum;
  logic [AMP_W-1:0] w_gap;
  logic [AMP_W-1:0] w_amp_nxt;

  // A key acts once per press: new non-zero code versus last cycle.
  assign w_accept = (keycode != KEY_NONE) && (keycode != r_prev_key);
  assign w_digit  = 4'(keycode - KEY_DIG_BS);

  always_comb begin
    w_level_nxt = r_level;
    w_lvl_cmd   = 1'b0;
    if (w_accept) begin
      if (keycode == KEY_ZERO) begin
        w_level_nxt = '0;
        w_lvl_cmd   = 1'b1;
      end else if ((keycode >= KEY_DIG_LO) && (keycode <= KEY_DIG_HI)) begin
        w_level_nxt = (w_digit > LVL_MAX) ? LVL_MAX : w_digit;
        w_lvl_cmd   = 1'b1;
      end else if (keycode == KEY_UP) begin
        w_level_nxt = (r_level >= LVL_MAX) ? LVL_MAX : r_level + 4'd1;
        w_lvl_cmd   = 1'b1;
      end else if (keycode == KEY_DN) begin
        w_level_nxt = (r_level == 4'd0) ? 4'd0 : r_level - 4'd1;
        w_lvl_cmd   = 1'b1;
      end
    end
  end

`ifdef AMP_MUTE_EN
  logic r_muted;
  logic w_mute_cmd;
  logic w_muted_nxt;

  // Mute toggles on its own key; any level key also unmutes.
  always_comb begin
    w_mute_cmd  = w_accept && (keycode == KEY_MUTE);
    w_muted_nxt = r_muted;
    if (w_mute_cmd) begin
      w_muted_nxt = ~r_muted;
    end else if (w_lvl_cmd) begin
      w_muted_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_muted <= 1'b0;
    end else begin
      r_muted <= w_muted_nxt;
    end
  end

  assign w_muted = r_muted;
  assign w_cmd   = w_lvl_cmd | w_mute_cmd;
`else
  assign w_muted = 1'b0;
  assign w_cmd   = w_lvl_cmd;
`endif

  assign w_eff_tgt = w_muted ? '0 : w_tgt_tbl[r_level];
  assign w_step    = (r_tick == CNT_LAST);

  // One slew step toward target; the widened sum and the gap test clamp without wrap.
  always_comb begin
    w_sum     = {1'b0, r_amp} + {1'b0, RAMP_STEP};
    w_gap     = r_amp - w_eff_tgt;
    w_amp_nxt = r_amp;
    if (r_amp < w_eff_tgt) begin
      w_amp_nxt = (w_sum > {1'b0, w_eff_tgt}) ? w_eff_tgt : w_sum[AMP_W-1:0];
    end else if (r_amp > w_eff_tgt) begin
      w_amp_nxt = (w_gap <= RAMP_STEP) ? w_eff_tgt : r_amp - RAMP_STEP;
    end
  end

  // A command restarts the tick phase, so its first step lands RAMP_DIV cycles later.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_amp      <= '1;
      r_level    <= LVL_MAX;
      r_prev_key <= KEY_NONE;
      r_tick     <= '0;
    end else begin
      r_prev_key <= keycode;
      r_level    <= w_level_nxt;
      if (w_cmd) begin
        r_tick <= '0;
      end else if (w_step) begin
        r_tick <= '0;
        r_amp  <= w_amp_nxt;
      end else begin
        r_tick <= r_tick + CNT_W'(1);
      end
    end
  end

  assign amplitude = r_amp;
  assign level     = r_level;
  assign muted     = w_muted;
  assign ramping   = (r_amp != w_eff_tgt);

endmodule

// File: tb/tb_amplitude_ramp_ctrl.sv
// Scoreboard bench for amplitude_ramp_ctrl (AMP_W=16, MAX_LEVEL=8, RAMP_STEP=16'h0800, RAMP_DIV=4).
// Mute scenarios follow AMP_MUTE_EN.
module tb_amplitude_ramp_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic [15:0] amplitude;
  logic [3:0]  level;
  logic        muted;
  logic        ramping;

  amplitude_ramp_ctrl #(
    .AMP_W    (16),
    .MAX_LEVEL(8),
    .RAMP_STEP(16'h0800),
    .RAMP_DIV (4)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .keycode  (keycode),
    .amplitude(amplitude),
    .level    (level),
    .muted    (muted),
    .ramping  (ramping)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] amp;
    logic [3:0]  lvl;
    logic        mut;
    logic        rmp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_amp, m_level, m_tick, m_prev;
  bit m_muted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int m_tgt(input int lvl, input bit mut);
    if (mut) return 0;
    if (lvl >= 8) return 'hFFFF;
    return lvl * 'h2000;
  endfunction

  // Reference model: advance one clock edge with keycode k.
  task automatic model_edge(input logic [7:0] k, input logic rst_n);
    int  t, kv, nl;
    bit  cmd, nm;
    if (!rst_n) begin
      m_amp = 'hFFFF; m_level = 8; m_muted = 0; m_prev = 0; m_tick = 0;
      return;
    end
    t   = m_tgt(m_level, m_muted);
    kv  = int'(k);
    cmd = 0; nl = m_level; nm = m_muted;
    if (kv != 0 && kv != m_prev) begin
      if (kv == 'h35) begin nl = 0; cmd = 1; end
      else if (kv >= 'h1E && kv <= 'h25) begin nl = (kv - 'h1D > 8) ? 8 : kv - 'h1D; cmd = 1; end
      else if (kv == 'h2E) begin nl = (m_level < 8) ? m_level + 1 : 8; cmd = 1; end
      else if (kv == 'h2D) begin nl = (m_level > 0) ? m_level - 1 : 0; cmd = 1; end
`ifdef AMP_MUTE_EN
      else if (kv == 'h10) begin nm = !m_muted; cmd = 1; end
`endif
      if (cmd && kv != 'h10) nm = 0;
    end
    if (cmd) m_tick = 0;
    else if (m_tick == 3) begin
      m_tick = 0;
      if (m_amp < t) m_amp = (m_amp + 'h800 > t) ? t : m_amp + 'h800;
      else if (m_amp > t) m_amp = (m_amp - 'h800 < t) ? t : m_amp - 'h800;
    end else m_tick++;
    m_level = nl; m_muted = nm; m_prev = kv;
  endtask

  // Drive one cycle, queue the model's prediction, compare after the edge.
  task automatic tick(input logic [7:0] k);
    exp_t e;
    keycode = k;
    model_edge(k, Reset_n);
    e.amp = 16'(m_amp);
    e.lvl = 4'(m_level);
    e.mut = m_muted;
    e.rmp = (m_amp != m_tgt(m_level, m_muted));
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_amp", 32'(amplitude), 32'(e.amp));
      check_eq("sb_lvl", 32'(level), 32'(e.lvl));
      check_eq("sb_mute", 32'(muted), 32'(e.mut));
      check_eq("sb_ramp", 32'(ramping), 32'(e.rmp));
    end
  endtask

  task automatic press(input logic [7:0] k);
    tick(k);
    tick(8'h00);
  endtask

  initial begin
    keycode = 8'h00;
    Reset_n = 1'b0;
    repeat (3) tick(8'h00);
    Reset_n = 1'b1;
    check_eq("rst_amp", 32'(amplitude), 32'hFFFF);
    check_eq("rst_lvl", 32'(level), 32'd8);
    check_eq("rst_mute", 32'(muted), 32'd0);
    check_eq("rst_ramp", 32'(ramping), 32'd0);

    // Digit 4: ramp down to 16'h8000 in 16 steps
    tick(8'h21);
    check_eq("dig4_lvl", 32'(level), 32'd4);
    check_eq("dig4_hold", 32'(amplitude), 32'hFFFF);
    repeat (4) tick(8'h00);
    check_eq("dig4_step1", 32'(amplitude), 32'hF7FF);
    repeat (59) tick(8'h00);
    check_eq("dig4_step15", 32'(amplitude), 32'h87FF);
    check_eq("dig4_ramping", 32'(ramping), 32'd1);
    tick(8'h00);
    check_eq("dig4_clamp", 32'(amplitude), 32'h8000);
    check_eq("dig4_done", 32'(ramping), 32'd0);

    // Held key acts once
    repeat (20) tick(8'h2E);
    check_eq("held_up", 32'(level), 32'd5);
    tick(8'h00);

    // Step up saturation, step down to zero
    repeat (4) press(8'h2E);
    check_eq("up_sat", 32'(level), 32'd8);
    repeat (9) press(8'h2D);
    check_eq("dn_sat", 32'(level), 32'd0);
    repeat (200) tick(8'h00);
    check_eq("dn_amp0", 32'(amplitude), 32'h0000);
    check_eq("dn_done", 32'(ramping), 32'd0);

    // Ignored code leaves state alone
    press(8'h04);
    check_eq("ign_lvl", 32'(level), 32'd0);

    // Retarget mid-ramp
    tick(8'h25);
    repeat (200) tick(8'h00);
    check_eq("full_amp", 32'(amplitude), 32'hFFFF);
    tick(8'h1E);
    check_eq("rt_lvl1", 32'(level), 32'd1);
    repeat (9) tick(8'h00);
    check_eq("rt_mid", 32'(amplitude), 32'hEFFF);
    tick(8'h25);
    check_eq("rt_lvl8", 32'(level), 32'd8);
    check_eq("rt_nojump", 32'(amplitude), 32'hEFFF);
    repeat (4) tick(8'h00);
    check_eq("rt_up1", 32'(amplitude), 32'hF7FF);
    repeat (4) tick(8'h00);
    check_eq("rt_full", 32'(amplitude), 32'hFFFF);
    check_eq("rt_done", 32'(ramping), 32'd0);

    // Reset mid-ramp snaps back
    tick(8'h1E);
    repeat (6) tick(8'h00);
    check_eq("mr_amp", 32'(amplitude), 32'hF7FF);
    Reset_n = 1'b0;
    tick(8'h00);
    Reset_n = 1'b1;
    check_eq("mr_rst_amp", 32'(amplitude), 32'hFFFF);
    check_eq("mr_rst_lvl", 32'(level), 32'd8);
    check_eq("mr_rst_ramp", 32'(ramping), 32'd0);

`ifdef AMP_MUTE_EN
    tick(8'h10);
    check_eq("mute_on", 32'(muted), 32'd1);
    check_eq("mute_lvl", 32'(level), 32'd8);
    repeat (200) tick(8'h00);
    check_eq("mute_amp0", 32'(amplitude), 32'h0000);
    tick(8'h10);
    check_eq("mute_off", 32'(muted), 32'd0);
    repeat (200) tick(8'h00);
    check_eq("unmute_full", 32'(amplitude), 32'hFFFF);
    press(8'h10);
    repeat (8) tick(8'h00);
    tick(8'h21);
    check_eq("lvlkey_unmute", 32'(muted), 32'd0);
    check_eq("lvlkey_lvl", 32'(level), 32'd4);
    repeat (200) tick(8'h00);
    check_eq("lvlkey_amp", 32'(amplitude), 32'h8000);
`else
    tick(8'h10);
    check_eq("nomute_flag", 32'(muted), 32'd0);
    check_eq("nomute_lvl", 32'(level), 32'd8);
    repeat (8) tick(8'h00);
    check_eq("nomute_amp", 32'(amplitude), 32'hFFFF);
    check_eq("nomute_ramp", 32'(ramping), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
